mpeg2_seq_ctrl: RTL and testbench
=================================

MPEG2_SEQ_CTRL -- requirements
Module: mpeg2_seq_ctrl

Interface
REQ-001 SHALL have parameter XL, default 7, meaning horizontal size field MSB (max width 16<<XL pixels).
REQ-002 SHALL have parameter YL, default 6, meaning vertical size field MSB (max height 16<<YL pixels).
REQ-003 SHALL have a single clock domain, with synchronous active-high reset, using the following ports (clock and reset first):
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- cfg_start  in  1  one-cycle pulse; start a sequence using the cfg_* values.
- cfg_xsize16  in  XL+1  width/16, sampled on cfg_start.
- cfg_ysize16  in  YL+1  height/16, sampled on cfg_start.
- cfg_nframes  in  16  frames to encode; 0 = unbounded until cfg_stop.
- cfg_stop  in  1  one-cycle pulse; end the sequence at the next frame boundary.
- s_valid  in  1  source beat valid (4 adjacent pixels of one row).
- s_ready  out  1  source beat accepted when s_valid&&s_ready.
- s_pix  in  96  {Y0..Y3,U0..U3,V0..V3}, 8 bits each, Y0 in the MSBs.
- enc_xsize16  out  XL+1  latched width to encoder.
- enc_ysize16  out  YL+1  latched height to encoder.
- enc_en  out  1  pixel-beat strobe to encoder.
- enc_pix  out  96  beat data to encoder.
- enc_sequence_stop  out  1  one-cycle sequence-stop pulse to encoder.
- enc_sequence_busy  in  1  encoder busy flag.
- busy  out  1  sequence in progress (state != IDLE).
- done  out  1  one-cycle pulse when the sequence is fully drained.
- err_cfg  out  1  one-cycle pulse when cfg_start is rejected.
- frame_cnt  out  16  complete frames forwarded in the current sequence.

Function
REQ-004 SHALL implement states IDLE, RUN, STOP, DRAIN.
REQ-005 IDLE: on cfg_start, SHALL validate 4 <= cfg_xsize16 <= 1<<XL and 4 <= cfg_ysize16 <= 1<<YL.
- If valid: latch sizes and nframes, clear counters and seen_busy, go to RUN.
- If invalid: pulse err_cfg the next cycle and stay in IDLE.
REQ-006 SHALL ignore cfg_start outside IDLE; latched sizes SHALL be stable while busy.
REQ-007 s_ready SHALL be combinational, high only in RUN with no end condition pending at a frame boundary.
REQ-008 Each handshake SHALL produce, exactly 1 cycle later, enc_en=1 and enc_pix=s_pix; otherwise enc_en=0 and enc_pix SHALL hold its value.
REQ-009 Beat counter SHALL run 0..4*xsize16-1 and wrap; row counter SHALL run 0..16*ysize16-1 and increment on beat wrap.
REQ-010 The handshake with beat=4*xsize16-1 and row=16*ysize16-1 is the frame end; SHALL increment frame_cnt there and wrap both counters to 0.
REQ-011 End condition SHALL be: frame_cnt reaches nonzero cfg_nframes, or stop_pending is set.
REQ-012 Frame-end handshake with end condition true: next state STOP.
REQ-013 RUN at a frame boundary (counters 0) with stop_pending: next state STOP, no further beats accepted.
REQ-014 cfg_stop in RUN SHALL set stop_pending; mid-frame, the current frame SHALL complete first.
REQ-015 cfg_stop in IDLE, STOP or DRAIN SHALL be ignored.
REQ-016 STOP state SHALL last exactly 1 cycle; enc_sequence_stop SHALL be high exactly in the cycle after STOP entry, i.e. 1 cycle after the final enc_en. Next state DRAIN.
REQ-017 seen_busy SHALL be set whenever enc_sequence_busy=1 in RUN, STOP or DRAIN.
REQ-018 DRAIN SHALL go to IDLE and pulse done when enc_sequence_busy=0 and either seen_busy=1 or frame_cnt=0 (empty sequence).
REQ-019 frame_cnt SHALL saturate at 16'hFFFF and hold its final value in IDLE until the next accepted cfg_start.
REQ-020 All outputs except s_ready SHALL be registered.

Reset
REQ-021 rst SHALL force the state to IDLE and clear counters, stop_pending and seen_busy.
REQ-022 rst SHALL set outputs: s_ready=0, enc_en=0, enc_pix=0, enc_sequence_stop=0, enc_xsize16=0, enc_ysize16=0, busy=0, done=0, err_cfg=0, frame_cnt=0.
REQ-023 rst mid-sequence SHALL abandon the sequence with no stop pulse and no done pulse.

Verification
REQ-024 cfg_start with x16=18, y16=13, nframes=2, source always valid:
- exactly 2*72*208=29952 enc_en beats;
- enc_sequence_stop 1 cycle after the last beat;
- frame_cnt=2;
- done after the model busy drops.
REQ-025 cfg_start with x16=3 or y16=65 -> err_cfg pulse, busy stays 0, no s_ready.
REQ-026 nframes=0, cfg_stop at beat 100 of frame 1 -> frame 1 completes, frame_cnt=2, stop pulse, s_ready=0 afterwards.
REQ-027 nframes=0, cfg_stop immediately after start -> STOP with 0 beats, stop pulse, done with busy never seen.
REQ-028 Random s_valid bubbles at x16=40, y16=20 -> enc_pix equals the accepted s_pix sequence in order, 1-cycle latency, no gaps or duplicates.
REQ-029 rst asserted during frame 0 row 5 -> all REQ-022 values the next cycle; a subsequent cfg_start works normally.

Source files
------------

// File: rtl/mpeg2_seq_ctrl_if.sv
// mpeg2_seq_ctrl_if: config, source, encoder and status signals of the sequence controller
interface mpeg2_seq_ctrl_if #(
  parameter int XL = 7,
  parameter int YL = 6
);
  logic        cfg_start;
  logic [XL:0] cfg_xsize16;
  logic [YL:0] cfg_ysize16;
  logic [15:0] cfg_nframes;
  logic        cfg_stop;
  logic        s_valid;
  logic        s_ready;
  logic [95:0] s_pix;
  logic [XL:0] enc_xsize16;
  logic [YL:0] enc_ysize16;
  logic        enc_en;
  logic [95:0] enc_pix;
  logic        enc_sequence_stop;
  logic        enc_sequence_busy;
  logic        busy;
  logic        done;
  logic        err_cfg;
  logic [15:0] frame_cnt;
  modport master (
    output cfg_start, cfg_xsize16, cfg_ysize16, cfg_nframes, cfg_stop, s_valid, s_pix, enc_sequence_busy,
    input  s_ready, enc_xsize16, enc_ysize16, enc_en, enc_pix, enc_sequence_stop, busy, done, err_cfg, frame_cnt
  );
  modport slave (
    input  cfg_start, cfg_xsize16, cfg_ysize16, cfg_nframes, cfg_stop, s_valid, s_pix, enc_sequence_busy,
    output s_ready, enc_xsize16, enc_ysize16, enc_en, enc_pix, enc_sequence_stop, busy, done, err_cfg, frame_cnt
  );
endinterface

// File: rtl/mpeg2_seq_ctrl.sv
// mpeg2_seq_ctrl: sequences pixel beats from a source into an MPEG2 encoder frame by frame
module mpeg2_seq_ctrl #(
  parameter int XL = 7,
  parameter int YL = 6
) (
  input logic clk,
  input logic rst,
  mpeg2_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, STOP, DRAIN} state_t;
  localparam logic [XL:0] XMIN = (XL+1)'(4);
  localparam logic [XL:0] XMAX = (XL+1)'(1) << XL;
  localparam logic [YL:0] YMIN = (YL+1)'(4);
  localparam logic [YL:0] YMAX = (YL+1)'(1) << YL;
  state_t state, state_nx;
  logic [XL:0] xs;
  logic [YL:0] ys;
  logic [15:0] nframes, fcnt, fc_nx;
  logic [XL+2:0] beat;
  logic [YL+4:0] row;
  logic [95:0] enc_pix;
  logic stop_pend, seen_busy, enc_en, enc_stop, busy_q, done_q, err_q;
  logic cfg_ok, start_ok, ready, hs, beat_last, row_last, at_bound, end_cond, frame_end, end_fe, drain_ok;
  // Decode handshake, frame position and the end-of-sequence conditions
  always_comb begin
    cfg_ok = bus.cfg_xsize16 >= XMIN && bus.cfg_xsize16 <= XMAX && bus.cfg_ysize16 >= YMIN && bus.cfg_ysize16 <= YMAX;
    start_ok = state == IDLE && bus.cfg_start && cfg_ok;
    beat_last = beat == {xs, 2'b00} - (XL+3)'(1);
    row_last = row == {ys, 4'b0000} - (YL+5)'(1);
    at_bound = ~|beat && ~|row;
    end_cond = (|nframes && fcnt >= nframes) || stop_pend;
    ready = state == RUN && !(at_bound && end_cond);
    hs = ready && bus.s_valid;
    frame_end = hs && beat_last && row_last;
    fc_nx = frame_end && ~&fcnt ? fcnt + 16'd1 : fcnt;
    end_fe = (|nframes && fc_nx >= nframes) || stop_pend;
    drain_ok = !bus.enc_sequence_busy && (seen_busy || ~|fcnt);
  end
  // Next state: a frame-end (or an idle boundary) with the end condition stops the sequence
  always_comb begin
    state_nx = state == IDLE ? (start_ok ? RUN : IDLE)
             : state == RUN ? ((frame_end && end_fe) || (at_bound && end_cond) ? STOP : RUN)
             : state == STOP ? DRAIN
             : (drain_ok ? IDLE : DRAIN);
  end
  // State register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // Registered outputs, position counters and sequence flags
  always_ff @(posedge clk) begin
    if (rst) begin
      xs <= '0;
      ys <= '0;
      nframes <= '0;
      fcnt <= '0;
      beat <= '0;
      row <= '0;
      enc_pix <= '0;
      stop_pend <= 1'b0;
      seen_busy <= 1'b0;
      enc_en <= 1'b0;
      enc_stop <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      enc_en <= hs;
      if (hs) enc_pix <= bus.s_pix;
      enc_stop <= state == STOP;
      busy_q <= state_nx != IDLE;
      done_q <= state == DRAIN && drain_ok;
      err_q <= state == IDLE && bus.cfg_start && !cfg_ok;
      if (start_ok) begin
        xs <= bus.cfg_xsize16;
        ys <= bus.cfg_ysize16;
        nframes <= bus.cfg_nframes;
        fcnt <= '0;
        beat <= '0;
        row <= '0;
        stop_pend <= 1'b0;
        seen_busy <= 1'b0;
      end else begin
        if (state != IDLE && bus.enc_sequence_busy) seen_busy <= 1'b1;
        if (state == RUN && bus.cfg_stop) stop_pend <= 1'b1;
        if (hs) beat <= beat_last ? '0 : beat + (XL+3)'(1);
        if (hs && beat_last) row <= row_last ? '0 : row + (YL+5)'(1);
        fcnt <= fc_nx;
      end
    end
  end
  assign bus.s_ready = ready;
  assign bus.enc_xsize16 = xs;
  assign bus.enc_ysize16 = ys;
  assign bus.enc_en = enc_en;
  assign bus.enc_pix = enc_pix;
  assign bus.enc_sequence_stop = enc_stop;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err_cfg = err_q;
  assign bus.frame_cnt = fcnt;
endmodule

// File: tb/tb_mpeg2_seq_ctrl.sv
// tb_mpeg2_seq_ctrl: directed sequences checked every cycle against a beat-count model
module tb_mpeg2_seq_ctrl;
  localparam int XL = 7;
  localparam int YL = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mpeg2_seq_ctrl_if #(.XL(XL), .YL(YL)) bus ();
  mpeg2_seq_ctrl #(.XL(XL), .YL(YL)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int src_mode = 0;
  bit chk_on = 1'b0;
  int n_en, n_stop, n_done, n_err, n_rdy, last_en_cyc, stop_cyc, done_cyc, drop_cyc;
  // Model: a sequence is just a count of accepted beats; frames = beats / beats_per_frame
  int m_phase = 0;
  int m_acc = 0;
  int m_fb = 1;
  int m_nf = 0;
  bit m_stop = 1'b0;
  bit m_seen = 1'b0;
  logic e_en = 1'b0, e_stopo = 1'b0, e_done = 1'b0, e_err = 1'b0, e_busy = 1'b0;
  logic [95:0] e_pix = '0;
  logic [15:0] e_fc = '0;
  logic [XL:0] e_xs = '0;
  logic [YL:0] e_ys = '0;
  function automatic bit size_ok(int x, int y);
    return x >= 4 && x <= (1 << XL) && y >= 4 && y <= (1 << YL);
  endfunction
  function bit m_end();
    return m_stop || (m_nf != 0 && m_acc / m_fb >= m_nf);
  endfunction
  function bit m_ready();
    return m_phase == 1 && !(m_acc % m_fb == 0 && m_end());
  endfunction
  always @(posedge clk) begin : model
    bit hs;
    int fr;
    if (rst) begin
      m_phase = 0; m_acc = 0; m_fb = 1; m_nf = 0; m_stop = 0; m_seen = 0;
      e_en = 0; e_stopo = 0; e_done = 0; e_err = 0; e_busy = 0; e_pix = '0; e_fc = '0; e_xs = '0; e_ys = '0;
    end else begin
      hs = m_ready() && bus.s_valid;
      e_en = hs;
      if (hs) e_pix = bus.s_pix;
      e_err = m_phase == 0 && bus.cfg_start && !size_ok(int'(bus.cfg_xsize16), int'(bus.cfg_ysize16));
      e_stopo = m_phase == 2;
      e_done = 0;
      if (m_phase == 0) begin
        if (bus.cfg_start && size_ok(int'(bus.cfg_xsize16), int'(bus.cfg_ysize16))) begin
          m_phase = 1; m_acc = 0; m_stop = 0; m_seen = 0;
          m_fb = 64 * int'(bus.cfg_xsize16) * int'(bus.cfg_ysize16);
          m_nf = int'(bus.cfg_nframes);
          e_xs = bus.cfg_xsize16; e_ys = bus.cfg_ysize16;
        end
      end else begin
        if (bus.enc_sequence_busy) m_seen = 1;
        if (m_phase == 1) begin
          if (hs) m_acc++;
          if (m_acc % m_fb == 0 && m_end()) m_phase = 2;
          if (bus.cfg_stop) m_stop = 1;
        end else if (m_phase == 2) m_phase = 3;
        else if (!bus.enc_sequence_busy && (m_seen || m_acc / m_fb == 0)) begin
          m_phase = 0;
          e_done = 1;
        end
      end
      e_busy = m_phase != 0;
      fr = m_acc / m_fb;
      e_fc = fr > 65535 ? 16'hFFFF : 16'(fr);
    end
  end
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  // Per-cycle comparison against the model plus event bookkeeping
  always @(negedge clk) begin
    if (chk_on) begin
      chk("s_ready", 96'(bus.s_ready), 96'(m_ready()));
      chk("enc_en", 96'(bus.enc_en), 96'(e_en));
      chk("enc_pix", bus.enc_pix, e_pix);
      chk("enc_sequence_stop", 96'(bus.enc_sequence_stop), 96'(e_stopo));
      chk("busy", 96'(bus.busy), 96'(e_busy));
      chk("done", 96'(bus.done), 96'(e_done));
      chk("err_cfg", 96'(bus.err_cfg), 96'(e_err));
      chk("frame_cnt", 96'(bus.frame_cnt), 96'(e_fc));
      chk("enc_xsize16", 96'(bus.enc_xsize16), 96'(e_xs));
      chk("enc_ysize16", 96'(bus.enc_ysize16), 96'(e_ys));
    end
    if (bus.enc_en === 1'b1) begin n_en++; last_en_cyc = cyc; end
    if (bus.enc_sequence_stop === 1'b1) begin n_stop++; stop_cyc = cyc; end
    if (bus.done === 1'b1) begin n_done++; done_cyc = cyc; end
    if (bus.err_cfg === 1'b1) n_err++;
    if (bus.s_ready === 1'b1) n_rdy++;
  end
  // Encoder stand-in: busy from the first beat until a few cycles after the stop pulse
  initial begin
    int tail = 0;
    bus.enc_sequence_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.enc_sequence_busy = 1'b0;
        tail = 0;
      end else begin
        if (bus.enc_en === 1'b1) bus.enc_sequence_busy = 1'b1;
        if (bus.enc_sequence_stop === 1'b1) tail = 6;
        else if (tail > 0) begin
          tail--;
          if (tail == 0 && bus.enc_sequence_busy) begin
            bus.enc_sequence_busy = 1'b0;
            drop_cyc = cyc;
          end
        end
      end
    end
  end
  // Source: off, always valid, or randomly bubbled, with fresh pixel data every cycle
  initial begin
    bus.s_valid = 1'b0;
    bus.s_pix = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.s_valid = src_mode == 1 ? 1'b1 : src_mode == 2 ? ($urandom_range(0, 99) < 60) : 1'b0;
      bus.s_pix = {$urandom, $urandom, $urandom};
    end
  end
  task automatic clr();
    n_en = 0; n_stop = 0; n_done = 0; n_err = 0; n_rdy = 0;
    last_en_cyc = -1; stop_cyc = -1; done_cyc = -1; drop_cyc = -1;
  endtask
  task automatic start(input int x, input int y, input int nf);
    @(posedge clk);
    #1;
    bus.cfg_start = 1'b1;
    bus.cfg_xsize16 = (XL+1)'(x);
    bus.cfg_ysize16 = (YL+1)'(y);
    bus.cfg_nframes = 16'(nf);
    @(posedge clk);
    #1;
    bus.cfg_start = 1'b0;
  endtask
  task automatic pulse_stop();
    @(posedge clk);
    #1 bus.cfg_stop = 1'b1;
    @(posedge clk);
    #1 bus.cfg_stop = 1'b0;
  endtask
  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_within_budget", 96'(n_done != 0), 96'(1));
  endtask
  task automatic wait_en(input int n, input int budget);
    int k = 0;
    while (n_en < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("beats_within_budget", 96'(n_en >= n), 96'(1));
  endtask
  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_stop = 1'b0;
    bus.cfg_xsize16 = '0;
    bus.cfg_ysize16 = '0;
    bus.cfg_nframes = '0;
    clr();
    @(posedge clk);
    #1 chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 96'(bus.busy), 96'(0));
    chk("reset_s_ready", 96'(bus.s_ready), 96'(0));
    chk("reset_frame_cnt", 96'(bus.frame_cnt), 96'(0));
    // Two full 18x13 frames with an always-valid source
    clr();
    src_mode = 1;
    start(18, 13, 2);
    wait_done(40000);
    repeat (3) @(negedge clk);
    chk("t1_beats", 96'(n_en), 96'(29952));
    chk("t1_frame_cnt", 96'(bus.frame_cnt), 96'(2));
    chk("t1_stop_after_last_beat", 96'(stop_cyc), 96'(last_en_cyc + 1));
    chk("t1_stop_pulses", 96'(n_stop), 96'(1));
    chk("t1_done_after_busy_drop", 96'(done_cyc > drop_cyc && drop_cyc > 0), 96'(1));
    chk("t1_done_pulses", 96'(n_done), 96'(1));
    // Rejected sizes: below minimum, above maximum height, above maximum width
    clr();
    start(3, 13, 1);
    start(18, 65, 1);
    start(129, 4, 1);
    repeat (3) @(negedge clk);
    chk("t2_err_pulses", 96'(n_err), 96'(3));
    chk("t2_ready_cycles", 96'(n_rdy), 96'(0));
    chk("t2_busy", 96'(bus.busy), 96'(0));
    chk("t2_frame_cnt_held", 96'(bus.frame_cnt), 96'(2));
    chk("t2_xsize_held", 96'(bus.enc_xsize16), 96'(18));
    // Unbounded 4x4 sequence stopped mid second frame
    clr();
    start(4, 4, 0);
    wait_en(1024 + 100, 5000);
    pulse_stop();
    wait_done(5000);
    repeat (3) @(negedge clk);
    chk("t3_beats", 96'(n_en), 96'(2048));
    chk("t3_frame_cnt", 96'(bus.frame_cnt), 96'(2));
    chk("t3_stop_pulses", 96'(n_stop), 96'(1));
    chk("t3_s_ready_after", 96'(bus.s_ready), 96'(0));
    // Stop right after start with no source data: empty sequence
    clr();
    src_mode = 0;
    start(4, 4, 0);
    bus.cfg_stop = 1'b1;
    @(posedge clk);
    #1 bus.cfg_stop = 1'b0;
    wait_done(100);
    chk("t4_beats", 96'(n_en), 96'(0));
    chk("t4_stop_pulses", 96'(n_stop), 96'(1));
    chk("t4_done_pulses", 96'(n_done), 96'(1));
    chk("t4_frame_cnt", 96'(bus.frame_cnt), 96'(0));
    // Bubbled 40x20 source, then reset in row 5 of frame 0
    clr();
    src_mode = 2;
    start(40, 20, 0);
    wait_en(5 * 160 + 10, 4000);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_s_ready", 96'(bus.s_ready), 96'(0));
    chk("t5_rst_enc_en", 96'(bus.enc_en), 96'(0));
    chk("t5_rst_enc_pix", bus.enc_pix, 96'(0));
    chk("t5_rst_stop", 96'(bus.enc_sequence_stop), 96'(0));
    chk("t5_rst_xsize", 96'(bus.enc_xsize16), 96'(0));
    chk("t5_rst_ysize", 96'(bus.enc_ysize16), 96'(0));
    chk("t5_rst_busy", 96'(bus.busy), 96'(0));
    chk("t5_rst_done", 96'(bus.done), 96'(0));
    chk("t5_rst_err", 96'(bus.err_cfg), 96'(0));
    chk("t5_rst_frame_cnt", 96'(bus.frame_cnt), 96'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    src_mode = 0;
    repeat (10) @(negedge clk);
    chk("t5_no_stop_pulse", 96'(n_stop), 96'(0));
    chk("t5_no_done_pulse", 96'(n_done), 96'(0));
    // Normal single-frame sequence after the reset
    clr();
    src_mode = 1;
    start(4, 4, 1);
    wait_done(3000);
    repeat (3) @(negedge clk);
    chk("t6_beats", 96'(n_en), 96'(1024));
    chk("t6_frame_cnt", 96'(bus.frame_cnt), 96'(1));
    chk("t6_done_pulses", 96'(n_done), 96'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
